ex_mem_reg: RTL and testbench
=============================

EX_MEM_REG -- requirements
Module: ex_mem_reg

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: width of data and PC fields.
REQ-002 SHALL have parameter REG_ADDR_WIDTH, default 5 (core_pkg value): width of register address.
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port rst  input  1  reset; asynchronous, active-high.
REQ-005 SHALL have port stall_i  input  1  hold all stored contents.
REQ-006 SHALL have port flush_i  input  1  replace the stored instruction with a bubble.
REQ-007 SHALL have port valid_EX_i  input  1  the EX-stage instruction is real.
REQ-008 SHALL have port RegWrite_EX_i, MemWrite_EX_i, MemRead_EX_i  input  1 each  EX-stage control bits.
REQ-009 SHALL have port WBSel_EX_i  input  wb_sel_e  EX-stage writeback select.
REQ-010 SHALL have port rd_addr_EX_i  input  REG_ADDR_WIDTH  destination register.
REQ-011 SHALL have port funct3_EX_i  input  3  memory access size/sign.
REQ-012 SHALL have port alu_result_EX_i, rs2_data_EX_i, pc_plus4_EX_i  input  DATA_WIDTH each  EX results.
REQ-013 SHALL have the matching *_MEM_o outputs for every field in REQ-007..REQ-012, each the same width as its input; valid_MEM_o corresponds to valid_EX_i.

Function
REQ-014 On each rising clk edge, priority SHALL be: rst > flush_i > stall_i > load.
REQ-015 On a load:
- valid_MEM_o <= valid_EX_i.
- RegWrite, MemWrite and MemRead outputs <= (input AND valid_EX_i).
- All other fields <= their inputs.
REQ-016 On flush_i = 1:
- valid_MEM_o, RegWrite_MEM_o, MemWrite_MEM_o and MemRead_MEM_o <= 0.
- Data and address fields hold their previous values.
REQ-017 On stall_i = 1 with flush_i = 0, every output SHALL hold its value, including valid.
REQ-018 flush_i = 1 together with stall_i = 1 SHALL produce a bubble, as in REQ-016.
REQ-019 Latency SHALL be exactly one cycle from input to output. Outputs SHALL be driven directly from flops, with no combinational input-to-output path.
REQ-020 RegWrite_MEM_o = 1 SHALL imply valid_MEM_o = 1 in every cycle; the forwarding logic relies on this.
REQ-021 rd_addr = 0 SHALL be passed unchanged; the consumer applies x0 suppression.
REQ-022 WBSel_MEM_o SHALL update only on a load. A bubble therefore never presents WB_MEM with RegWrite = 1.

Reset
REQ-023 While rst = 1, asynchronously:
- All control outputs and valid_MEM_o = 0.
- WBSel_MEM_o = the first enumerator of wb_sel_e.
- All data, address and funct3 outputs = 0.
REQ-024 Reset asserted mid-stall or mid-flush SHALL override both. The first edge after deassertion SHALL perform a normal REQ-014 evaluation.

Configuration
REQ-025 Macro EX_MEM_BUBBLE_CNT_EN, when defined, SHALL add output bubble_cnt_o  output  32  count of clock edges that end with valid_MEM_o = 0 while stall_i = 0.
- The count saturates at 32'hFFFF_FFFF.
- It resets to 0 on rst.
REQ-026 Without EX_MEM_BUBBLE_CNT_EN, the bubble_cnt_o port and its counter SHALL be absent. All other behaviour SHALL be identical.

Verification
REQ-027 Scenario: reset, then load valid_EX_i = 1, RegWrite = 1, rd = 5, alu = 32'h1234 -> next cycle RegWrite_MEM_o = 1, rd_addr_MEM_o = 5, alu_result_MEM_o = 32'h1234, valid_MEM_o = 1.
REQ-028 Scenario: load with valid_EX_i = 0, RegWrite_EX_i = 1, MemWrite_EX_i = 1 -> valid_MEM_o = 0, RegWrite_MEM_o = 0, MemWrite_MEM_o = 0.
REQ-029 Scenario: stall_i = 1 for 3 cycles while inputs change each cycle -> outputs keep their pre-stall values for all 3 cycles.
REQ-030 Scenario: flush_i = 1 and stall_i = 1 together while holding a valid load instruction -> valid_MEM_o = 0, MemRead_MEM_o = 0, alu_result_MEM_o unchanged.
REQ-031 Scenario: rst pulsed asynchronously between clock edges while a valid store is held -> all outputs 0 immediately; bubble_cnt_o = 0 when EX_MEM_BUBBLE_CNT_EN is defined.
REQ-032 Scenario: with EX_MEM_BUBBLE_CNT_EN, 4 unstalled bubble cycles followed by 2 stalled bubble cycles -> bubble_cnt_o = 4.

Source files
------------

// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register with stall hold, flush-to-bubble and async reset.
// Optional: define EX_MEM_BUBBLE_CNT_EN to add the 32-bit saturating bubble_cnt_o counter.

package core_pkg;
  localparam int REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2
  } wb_sel_e;
endpackage

module ex_mem_reg #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = core_pkg::REG_ADDR_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      stall_i,
  input  logic                      flush_i,
  input  logic                      valid_EX_i,
  input  logic                      RegWrite_EX_i,
  input  logic                      MemWrite_EX_i,
  input  logic                      MemRead_EX_i,
  input  core_pkg::wb_sel_e         WBSel_EX_i,
  input  logic [REG_ADDR_WIDTH-1:0] rd_addr_EX_i,
  input  logic [2:0]                funct3_EX_i,
  input  logic [DATA_WIDTH-1:0]     alu_result_EX_i,
  input  logic [DATA_WIDTH-1:0]     rs2_data_EX_i,
  input  logic [DATA_WIDTH-1:0]     pc_plus4_EX_i,
  output logic                      valid_MEM_o,
  output logic                      RegWrite_MEM_o,
  output logic                      MemWrite_MEM_o,
  output logic                      MemRead_MEM_o,
  output core_pkg::wb_sel_e         WBSel_MEM_o,
  output logic [REG_ADDR_WIDTH-1:0] rd_addr_MEM_o,
  output logic [2:0]                funct3_MEM_o,
  output logic [DATA_WIDTH-1:0]     alu_result_MEM_o,
  output logic [DATA_WIDTH-1:0]     rs2_data_MEM_o,
  output logic [DATA_WIDTH-1:0]     pc_plus4_MEM_o
`ifdef EX_MEM_BUBBLE_CNT_EN
  , output logic [31:0]             bubble_cnt_o
`endif
);

  // Control bits are qualified by valid so RegWrite_MEM_o can never be set
  // without valid_MEM_o; forwarding logic downstream depends on that.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      valid_MEM_o      <= 1'b0;
      RegWrite_MEM_o   <= 1'b0;
      MemWrite_MEM_o   <= 1'b0;
      MemRead_MEM_o    <= 1'b0;
      WBSel_MEM_o      <= core_pkg::WB_ALU;
      rd_addr_MEM_o    <= '0;
      funct3_MEM_o     <= '0;
      alu_result_MEM_o <= '0;
      rs2_data_MEM_o   <= '0;
      pc_plus4_MEM_o   <= '0;
    end else if (flush_i) begin
      // Bubble: kill the instruction, leave data fields and WBSel untouched.
      valid_MEM_o    <= 1'b0;
      RegWrite_MEM_o <= 1'b0;
      MemWrite_MEM_o <= 1'b0;
      MemRead_MEM_o  <= 1'b0;
    end else if (!stall_i) begin
      valid_MEM_o      <= valid_EX_i;
      RegWrite_MEM_o   <= RegWrite_EX_i & valid_EX_i;
      MemWrite_MEM_o   <= MemWrite_EX_i & valid_EX_i;
      MemRead_MEM_o    <= MemRead_EX_i & valid_EX_i;
      WBSel_MEM_o      <= WBSel_EX_i;
      rd_addr_MEM_o    <= rd_addr_EX_i;
      funct3_MEM_o     <= funct3_EX_i;
      alu_result_MEM_o <= alu_result_EX_i;
      rs2_data_MEM_o   <= rs2_data_EX_i;
      pc_plus4_MEM_o   <= pc_plus4_EX_i;
    end
  end

`ifdef EX_MEM_BUBBLE_CNT_EN
  // An unstalled edge leaves valid_MEM_o low exactly when it flushes or loads an invalid slot.
  logic bubble_edge;
  assign bubble_edge = !stall_i && (flush_i || !valid_EX_i);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bubble_cnt_o <= '0;
    end else if (bubble_edge && (bubble_cnt_o != 32'hFFFF_FFFF)) begin
      bubble_cnt_o <= bubble_cnt_o + 32'd1;
    end
  end
`else
  // Counter not built in this configuration.
`endif

endmodule

// File: tb/tb_ex_mem_reg.sv
// Randomized self-checking bench for ex_mem_reg against a rule-level reference model.
// Builds with or without EX_MEM_BUBBLE_CNT_EN.

module tb_ex_mem_reg;
  import core_pkg::*;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          stall_i, flush_i, valid_EX_i;
  logic          RegWrite_EX_i, MemWrite_EX_i, MemRead_EX_i;
  wb_sel_e       WBSel_EX_i;
  logic [AW-1:0] rd_addr_EX_i;
  logic [2:0]    funct3_EX_i;
  logic [DW-1:0] alu_result_EX_i, rs2_data_EX_i, pc_plus4_EX_i;

  logic          valid_MEM_o, RegWrite_MEM_o, MemWrite_MEM_o, MemRead_MEM_o;
  wb_sel_e       WBSel_MEM_o;
  logic [AW-1:0] rd_addr_MEM_o;
  logic [2:0]    funct3_MEM_o;
  logic [DW-1:0] alu_result_MEM_o, rs2_data_MEM_o, pc_plus4_MEM_o;
`ifdef EX_MEM_BUBBLE_CNT_EN
  logic [31:0]   bubble_cnt_o;
`endif

  int vectors = 0;
  int miscompares = 0;

  ex_mem_reg #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i),
    .valid_EX_i(valid_EX_i), .RegWrite_EX_i(RegWrite_EX_i),
    .MemWrite_EX_i(MemWrite_EX_i), .MemRead_EX_i(MemRead_EX_i),
    .WBSel_EX_i(WBSel_EX_i), .rd_addr_EX_i(rd_addr_EX_i),
    .funct3_EX_i(funct3_EX_i), .alu_result_EX_i(alu_result_EX_i),
    .rs2_data_EX_i(rs2_data_EX_i), .pc_plus4_EX_i(pc_plus4_EX_i),
    .valid_MEM_o(valid_MEM_o), .RegWrite_MEM_o(RegWrite_MEM_o),
    .MemWrite_MEM_o(MemWrite_MEM_o), .MemRead_MEM_o(MemRead_MEM_o),
    .WBSel_MEM_o(WBSel_MEM_o), .rd_addr_MEM_o(rd_addr_MEM_o),
    .funct3_MEM_o(funct3_MEM_o), .alu_result_MEM_o(alu_result_MEM_o),
    .rs2_data_MEM_o(rs2_data_MEM_o), .pc_plus4_MEM_o(pc_plus4_MEM_o)
`ifdef EX_MEM_BUBBLE_CNT_EN
    , .bubble_cnt_o(bubble_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  // Expected architectural contents of the MEM stage.
  typedef struct {
    logic        valid, rw, mw, mr;
    logic [1:0]  wb;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [31:0] alu, rs2, pc4;
    longint      bubbles;
  } model_t;

  model_t m;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m = '{valid: 1'b0, rw: 1'b0, mw: 1'b0, mr: 1'b0, wb: 2'd0, rd: '0, f3: '0,
          alu: '0, rs2: '0, pc4: '0, bubbles: 0};
  endfunction

  // One clock edge, evaluated from the stated rules rather than from any RTL structure.
  function automatic void model_edge();
    bit ends_empty;
    if (flush_i) begin
      {m.valid, m.rw, m.mw, m.mr} = 4'b0000;
    end else if (!stall_i) begin
      m.valid = valid_EX_i;
      m.rw    = valid_EX_i ? RegWrite_EX_i : 1'b0;
      m.mw    = valid_EX_i ? MemWrite_EX_i : 1'b0;
      m.mr    = valid_EX_i ? MemRead_EX_i : 1'b0;
      m.wb    = WBSel_EX_i;
      m.rd    = rd_addr_EX_i;
      m.f3    = funct3_EX_i;
      m.alu   = alu_result_EX_i;
      m.rs2   = rs2_data_EX_i;
      m.pc4   = pc_plus4_EX_i;
    end
    ends_empty = (m.valid == 1'b0);
    if (!stall_i && ends_empty && m.bubbles < 64'hFFFF_FFFF) m.bubbles++;
  endfunction

  task automatic compare_all(input string tag);
    check({tag, ".valid"}, 64'(valid_MEM_o), 64'(m.valid));
    check({tag, ".regwrite"}, 64'(RegWrite_MEM_o), 64'(m.rw));
    check({tag, ".memwrite"}, 64'(MemWrite_MEM_o), 64'(m.mw));
    check({tag, ".memread"}, 64'(MemRead_MEM_o), 64'(m.mr));
    check({tag, ".wbsel"}, 64'(WBSel_MEM_o), 64'(m.wb));
    check({tag, ".rd"}, 64'(rd_addr_MEM_o), 64'(m.rd));
    check({tag, ".funct3"}, 64'(funct3_MEM_o), 64'(m.f3));
    check({tag, ".alu"}, 64'(alu_result_MEM_o), 64'(m.alu));
    check({tag, ".rs2"}, 64'(rs2_data_MEM_o), 64'(m.rs2));
    check({tag, ".pc4"}, 64'(pc_plus4_MEM_o), 64'(m.pc4));
    check({tag, ".rw_implies_valid"}, 64'(RegWrite_MEM_o & ~valid_MEM_o), 64'd0);
`ifdef EX_MEM_BUBBLE_CNT_EN
    check({tag, ".bubble_cnt"}, 64'(bubble_cnt_o), 64'(m.bubbles));
`endif
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    if (!rst) model_edge();
    #1;
    compare_all(tag);
  endtask

  task automatic drive_instr(input logic v, input logic rw, input logic mw, input logic mr,
                             input logic [4:0] rd, input logic [31:0] alu);
    valid_EX_i      = v;
    RegWrite_EX_i   = rw;
    MemWrite_EX_i   = mw;
    MemRead_EX_i    = mr;
    rd_addr_EX_i    = rd;
    alu_result_EX_i = alu;
  endtask

  task automatic drive_random_data();
    WBSel_EX_i      = wb_sel_e'(2'($urandom_range(0, 2)));
    rd_addr_EX_i    = 5'($urandom);
    funct3_EX_i     = 3'($urandom);
    alu_result_EX_i = $urandom;
    rs2_data_EX_i   = $urandom;
    pc_plus4_EX_i   = $urandom;
    RegWrite_EX_i   = 1'($urandom);
    MemWrite_EX_i   = 1'($urandom);
    MemRead_EX_i    = 1'($urandom);
    valid_EX_i      = ($urandom_range(0, 9) < 7);
  endtask

  task automatic async_reset(input string tag);
    #3 rst = 1'b1;
    #1;
    model_reset();
    compare_all(tag);
    #1 rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] held_alu;
    stall_i = 1'b0;
    flush_i = 1'b0;
    rst     = 1'b1;
    drive_random_data();
    model_reset();
    #2;
    compare_all("reset");
    // Edges under reset must not load anything.
    @(posedge clk);
    #1;
    compare_all("reset_held");
    #2 rst = 1'b0;

    // Basic load into x5.
    drive_instr(1'b1, 1'b1, 1'b0, 1'b0, 5'd5, 32'h1234);
    tick("load_rd5");
    check("load_rd5.alu_const", 64'(alu_result_MEM_o), 64'h1234);
    check("load_rd5.rd_const", 64'(rd_addr_MEM_o), 64'd5);

    // Invalid slot must not carry write enables.
    drive_instr(1'b0, 1'b1, 1'b1, 1'b0, 5'd7, 32'hdead);
    tick("load_invalid");
    check("load_invalid.rw_const", 64'(RegWrite_MEM_o), 64'd0);

    // rd = 0 passes through unchanged.
    drive_instr(1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 32'h55);
    tick("load_x0");

    // Three stalled cycles with changing inputs keep the pre-stall contents.
    drive_instr(1'b1, 1'b0, 1'b0, 1'b1, 5'd9, 32'hCAFE_0001);
    tick("pre_stall");
    held_alu = alu_result_MEM_o;
    stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_random_data();
      tick("stall");
      check("stall.alu_const", 64'(alu_result_MEM_o), 64'hCAFE_0001);
    end

    // Flush wins over stall: bubble, data held.
    flush_i = 1'b1;
    drive_instr(1'b1, 1'b0, 1'b0, 1'b1, 5'd3, 32'hBEEF);
    tick("flush_stall");
    check("flush_stall.alu_held", 64'(alu_result_MEM_o), 64'(held_alu));
    stall_i = 1'b0;
    flush_i = 1'b0;

    // Async reset between edges while a valid store is held.
    drive_instr(1'b1, 1'b0, 1'b1, 1'b0, 5'd12, 32'h1000);
    tick("store");
    async_reset("async_rst_store");
    tick("post_reset_load");

`ifdef EX_MEM_BUBBLE_CNT_EN
    async_reset("cnt_reset");
    drive_instr(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    for (int i = 0; i < 4; i++) tick("bubble_run");
    stall_i = 1'b1;
    for (int i = 0; i < 2; i++) tick("bubble_stalled");
    check("bubble_cnt_four", 64'(bubble_cnt_o), 64'd4);
    stall_i = 1'b0;
`endif

    // Randomized mix of loads, stalls, flushes and occasional async resets.
    for (int i = 0; i < 400; i++) begin
      drive_random_data();
      stall_i = ($urandom_range(0, 3) == 0);
      flush_i = ($urandom_range(0, 6) == 0);
      if ($urandom_range(0, 49) == 0) async_reset("rand_rst");
      tick("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
